matbi_watch_fnd_scan: RTL and testbench

Display-side consumer of the watch counter: takes binary `sec`/`min`/`hour` values and drives a 6-digit, common-anode, multiplexed 7-segment (FND) display. Each frame snapshots the time once, converts it to BCD, then scans the digits one at a time. A programmable dwell time sets how long each digit stays lit, and guard gaps between digits suppress ghosting. The block sits between the watch counter outputs and the board FND pins.

---
 rtl/matbi_fnd_pkg.sv | 44 ++++
 rtl/matbi_fnd_seg_dec.sv | 21 ++
 rtl/matbi_watch_fnd_scan.sv | 149 ++++++++++++++
 tb/tb_matbi_watch_fnd_scan.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/matbi_fnd_pkg.sv
// Shared definitions for the watch FND scanner: FSM encoding, segment codes, digit count.
package matbi_fnd_pkg;

    typedef enum logic [1:0] {
        S_LATCH = 2'd0,
        S_GUARD = 2'd1,
        S_SHOW  = 2'd2
    } state_t;

    localparam int NUM_DIGITS = 6;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    function automatic logic [6:0] seg_of(input logic [3:0] bcd);
        logic [6:0] code;
        case (bcd)
            4'd0:    code = SEG_0;
            4'd1:    code = SEG_1;
            4'd2:    code = SEG_2;
            4'd3:    code = SEG_3;
            4'd4:    code = SEG_4;
            4'd5:    code = SEG_5;
            4'd6:    code = SEG_6;
            4'd7:    code = SEG_7;
            4'd8:    code = SEG_8;
            4'd9:    code = SEG_9;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/matbi_fnd_seg_dec.sv
// BCD to active-low 7-segment decoder; dash overrides blank, blank overrides the digit.
module matbi_fnd_seg_dec
    import matbi_fnd_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    input  logic       dash,
    output logic [6:0] seg
);

    // Pick dash, blank or the decoded digit
    always_comb begin
        seg = SEG_BLANK;
        if (dash) begin
            seg = SEG_DASH;
        end else if (!blank) begin
            seg = seg_of(bcd);
        end
    end

endmodule

// File: rtl/matbi_watch_fnd_scan.sv
// Multiplexed 6-digit FND driver for the watch: snapshot per frame, guard gap, dwell per digit.
//
// state   | meaning
// S_LATCH | capture sec/min/hour snapshot, reset digit index, outputs blank
// S_GUARD | blank gap of P_GUARD cycles before the next digit
// S_SHOW  | current digit lit for max(i_dwell,1) cycles
module matbi_watch_fnd_scan
    import matbi_fnd_pkg::*;
#(
    parameter int P_SEC_BIT       = 6,
    parameter int P_MIN_BIT       = 6,
    parameter int P_HOUR_BIT      = 5,
    parameter int P_DWELL_BIT     = 20,
    parameter int P_GUARD         = 4,
    parameter int P_HOUR_LZ_BLANK = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [P_SEC_BIT-1:0]   i_sec,
    input  logic [P_MIN_BIT-1:0]   i_min,
    input  logic [P_HOUR_BIT-1:0]  i_hour,
    input  logic [P_DWELL_BIT-1:0] i_dwell,
    output logic [5:0]             o_an,
    output logic [6:0]             o_seg,
    output logic                   o_dp
);

    localparam int GUARD_BIT = (P_GUARD > 1) ? $clog2(P_GUARD) : 1;
    localparam logic [GUARD_BIT-1:0] GUARD_INIT = GUARD_BIT'(P_GUARD - 1);
    localparam logic [2:0] LAST_IDX = 3'(NUM_DIGITS - 1);
    localparam bit LZ_BLANK = (P_HOUR_LZ_BLANK != 0);

    state_t                 state;
    logic [2:0]             idx;
    logic [GUARD_BIT-1:0]   guard_cnt;
    logic [P_DWELL_BIT-1:0] dwell_cnt;
    logic [P_SEC_BIT-1:0]   snap_sec;
    logic [P_MIN_BIT-1:0]   snap_min;
    logic [P_HOUR_BIT-1:0]  snap_hour;

    logic [P_DWELL_BIT-1:0] dwell_init;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens, hour_ones, hour_tens;
    logic       sec_bad, min_bad, hour_bad;
    logic [3:0] dig_bcd;
    logic       dig_blank, dig_dash;
    logic [6:0] dig_seg;

    // A dwell of zero behaves as one; the counter is terminal at zero
    assign dwell_init = (i_dwell == '0) ? '0 : i_dwell - P_DWELL_BIT'(1);

    assign sec_ones  = 4'(snap_sec  % P_SEC_BIT'(10));
    assign sec_tens  = 4'(snap_sec  / P_SEC_BIT'(10));
    assign min_ones  = 4'(snap_min  % P_MIN_BIT'(10));
    assign min_tens  = 4'(snap_min  / P_MIN_BIT'(10));
    assign hour_ones = 4'(snap_hour % P_HOUR_BIT'(10));
    assign hour_tens = 4'(snap_hour / P_HOUR_BIT'(10));
    assign sec_bad   = snap_sec  > P_SEC_BIT'(59);
    assign min_bad   = snap_min  > P_MIN_BIT'(59);
    assign hour_bad  = snap_hour > P_HOUR_BIT'(23);

    // Select the BCD value and dash/blank flags for the digit being scanned
    always_comb begin
        dig_bcd   = '0;
        dig_blank = 1'b0;
        dig_dash  = 1'b0;
        case (idx)
            3'd0: begin dig_bcd = sec_ones;  dig_dash = sec_bad;  end
            3'd1: begin dig_bcd = sec_tens;  dig_dash = sec_bad;  end
            3'd2: begin dig_bcd = min_ones;  dig_dash = min_bad;  end
            3'd3: begin dig_bcd = min_tens;  dig_dash = min_bad;  end
            3'd4: begin dig_bcd = hour_ones; dig_dash = hour_bad; end
            3'd5: begin
                dig_bcd   = hour_tens;
                dig_dash  = hour_bad;
                dig_blank = LZ_BLANK && (snap_hour < P_HOUR_BIT'(10));
            end
            default: dig_blank = 1'b1;
        endcase
    end

    matbi_fnd_seg_dec u_seg_dec (
        .bcd   (dig_bcd),
        .blank (dig_blank),
        .dash  (dig_dash),
        .seg   (dig_seg)
    );

    // Frame sequencer: latch, then guard/show for each of the six digits
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_LATCH;
            idx       <= '0;
            guard_cnt <= '0;
            dwell_cnt <= '0;
            snap_sec  <= '0;
            snap_min  <= '0;
            snap_hour <= '0;
        end else begin
            case (state)
                S_LATCH: begin
                    snap_sec  <= i_sec;
                    snap_min  <= i_min;
                    snap_hour <= i_hour;
                    idx       <= '0;
                    guard_cnt <= GUARD_INIT;
                    state     <= S_GUARD;
                end
                S_GUARD: begin
                    if (guard_cnt == '0) begin
                        dwell_cnt <= dwell_init;
                        state     <= S_SHOW;
                    end else begin
                        guard_cnt <= guard_cnt - GUARD_BIT'(1);
                    end
                end
                S_SHOW: begin
                    if (dwell_cnt != '0) begin
                        dwell_cnt <= dwell_cnt - P_DWELL_BIT'(1);
                    end else if (idx == LAST_IDX) begin
                        state <= S_LATCH;
                    end else begin
                        idx       <= idx + 3'd1;
                        guard_cnt <= GUARD_INIT;
                        state     <= S_GUARD;
                    end
                end
                default: state <= S_LATCH;
            endcase
        end
    end

    // Registered pins, one cycle behind the state; anode and segments update together
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_an  <= 6'h3F;
            o_seg <= SEG_BLANK;
            o_dp  <= 1'b1;
        end else if (state == S_SHOW) begin
            o_an  <= ~(6'd1 << idx);
            o_seg <= dig_seg;
            o_dp  <= ~(((idx == 3'd2) || (idx == 3'd4)) && !snap_sec[0]);
        end else begin
            o_an  <= 6'h3F;
            o_seg <= SEG_BLANK;
            o_dp  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_matbi_watch_fnd_scan.sv
// Directed bench for the FND scanner: two instances, hour-tens blanking off and on.
module tb_matbi_watch_fnd_scan;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  i_sec, i_min;
    logic [4:0]  i_hour;
    logic [19:0] i_dwell;
    logic [5:0]  an0, an1;
    logic [6:0]  seg0, seg1;
    logic        dp0, dp1;
    bit          sel = 1'b0;

    matbi_watch_fnd_scan #(.P_HOUR_LZ_BLANK(0)) dut (
        .clk(clk), .reset(reset), .i_sec(i_sec), .i_min(i_min), .i_hour(i_hour),
        .i_dwell(i_dwell), .o_an(an0), .o_seg(seg0), .o_dp(dp0)
    );

    matbi_watch_fnd_scan #(.P_HOUR_LZ_BLANK(1)) dut_lz (
        .clk(clk), .reset(reset), .i_sec(i_sec), .i_min(i_min), .i_hour(i_hour),
        .i_dwell(i_dwell), .o_an(an1), .o_seg(seg1), .o_dp(dp1)
    );

    always #5 clk = ~clk;

    wire [5:0] an_s  = sel ? an1  : an0;
    wire [6:0] seg_s = sel ? seg1 : seg0;
    wire       dp_s  = sel ? dp1  : dp0;

    int n_chk = 0;
    int n_pass = 0;
    int multi_an = 0;
    int seg_glitch = 0;
    int frame_cycles;
    string ftag;

    logic [6:0] e_seg [6];
    bit         e_dp  [6];
    int         e_len [6];

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Continuous watch on both instances: at most one anode low, segments stable while lit
    logic [5:0] pa0 = 6'h3F, pa1 = 6'h3F;
    logic [6:0] ps0 = 7'h7F, ps1 = 7'h7F;
    always @(negedge clk) begin
        if (!reset) begin
            if ($countones(~an0) > 1 || $countones(~an1) > 1) multi_an++;
            if (an0 != 6'h3F && an0 == pa0 && seg0 != ps0) seg_glitch++;
            if (an1 != 6'h3F && an1 == pa1 && seg1 != ps1) seg_glitch++;
        end
        pa0 = an0; pa1 = an1; ps0 = seg0; ps1 = seg1;
    end

    // Count blank cycles, check the lit digit, count lit cycles
    task automatic digit(input int k, input int gap, input int dw_new);
        int g = 0;
        int l = 0;
        logic [5:0] an_exp;
        an_exp = ~(6'd1 << k);
        while (an_s == 6'h3F && g < 400) begin g++; @(negedge clk); end
        chk($sformatf("%s d%0d gap", ftag, k), g, gap);
        chk($sformatf("%s d%0d an", ftag, k), an_s, an_exp);
        chk($sformatf("%s d%0d seg", ftag, k), seg_s, e_seg[k]);
        chk($sformatf("%s d%0d dp", ftag, k), dp_s, e_dp[k]);
        if (dw_new >= 0) i_dwell = 20'(dw_new);
        while (an_s == an_exp && l < 400) begin l++; @(negedge clk); end
        chk($sformatf("%s d%0d len", ftag, k), l, e_len[k]);
        frame_cycles += g + l;
    endtask

    task automatic frame(input string tag, input int chg_digit, input logic [5:0] ns,
                         input logic [5:0] nm, input logic [4:0] nh,
                         input int dw_digit, input int dw_val);
        ftag = tag;
        frame_cycles = 0;
        for (int k = 0; k < 6; k++) begin
            digit(k, (k == 0) ? 5 : 4, (k == dw_digit) ? dw_val : -1);
            if (k == chg_digit) begin
                i_sec = ns; i_min = nm; i_hour = nh;
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int w;
        i_sec = 6'd56; i_min = 6'd34; i_hour = 5'd12; i_dwell = 20'd8;
        repeat (3) @(negedge clk);
        chk("reset an", an0, 6'h3F);
        chk("reset seg", seg0, 7'h7F);
        chk("reset dp", dp0, 1);
        chk("reset lz an", an1, 6'h3F);
        reset = 1'b0;
        @(negedge clk);

        // 12:34:56, dwell 8
        e_seg = '{7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
        e_dp  = '{1, 1, 0, 1, 0, 1};
        e_len = '{8, 8, 8, 8, 8, 8};
        frame("f1", 2, 6'd59, 6'd59, 5'd23, -1, 0);
        chk("f1 frame len", frame_cycles, 73);

        // 23:59:59, input switches to 00:00:00 mid-frame
        e_seg = '{7'h10, 7'h12, 7'h10, 7'h12, 7'h30, 7'h24};
        e_dp  = '{1, 1, 1, 1, 1, 1};
        frame("f2", 2, 6'd0, 6'd0, 5'd0, -1, 0);

        e_seg = '{7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
        e_dp  = '{1, 1, 0, 1, 0, 1};
        frame("f3", 2, 6'd61, 6'd34, 5'd24, -1, 0);

        // out-of-range sec and hour
        e_seg = '{7'h3F, 7'h3F, 7'h19, 7'h30, 7'h3F, 7'h3F};
        e_dp  = '{1, 1, 1, 1, 1, 1};
        frame("f4", 2, 6'd56, 6'd34, 5'd7, -1, 0);

        // 07:34:56 on the leading-zero-blank instance
        sel = 1'b1;
        e_seg = '{7'h02, 7'h12, 7'h19, 7'h30, 7'h78, 7'h7F};
        e_dp  = '{1, 1, 0, 1, 0, 1};
        frame("f5lz", -1, 6'd0, 6'd0, 5'd0, -1, 0);
        sel = 1'b0;
        i_dwell = 20'd0;

        // dwell 0 acts as 1; 3 written while digit 2 is lit applies from digit 3
        e_seg = '{7'h02, 7'h12, 7'h19, 7'h30, 7'h78, 7'h40};
        e_len = '{1, 1, 1, 3, 3, 3};
        frame("f6", -1, 6'd0, 6'd0, 5'd0, 2, 3);
        chk("f6 frame len", frame_cycles, 37);

        // reset pulse while digit 4 is lit
        w = 0;
        while (an0 != 6'h2F && w < 400) begin w++; @(negedge clk); end
        chk("pre-reset an d4", an0, 6'h2F);
        reset = 1'b1;
        @(negedge clk);
        chk("mid reset an", an0, 6'h3F);
        chk("mid reset seg", seg0, 7'h7F);
        chk("mid reset dp", dp0, 1);
        @(negedge clk);
        reset = 1'b0;
        i_sec = 6'd56; i_min = 6'd34; i_hour = 5'd12; i_dwell = 20'd8;
        @(negedge clk);
        e_seg = '{7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
        e_dp  = '{1, 1, 0, 1, 0, 1};
        e_len = '{8, 8, 8, 8, 8, 8};
        frame("f7", -1, 6'd0, 6'd0, 5'd0, -1, 0);
        chk("f7 frame len", frame_cycles, 73);

        chk("multi anode cycles", multi_an, 0);
        chk("seg change while lit", seg_glitch, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
